// File: rtl/cache_sa_wt_if.sv
// LSU request/response and memory refill/write-through bus for the set-associative cache.
// The master modport is the LSU + memory side, the slave modport is the cache itself.
interface cache_sa_wt_if #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BYTES = 16
);
  localparam int BLK_W = 8 * BLOCK_BYTES;

  logic              inv_all;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_hit;
  logic              resp_err;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_valid;
  logic [BLK_W-1:0]  mem_rd_data;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic [3:0]        mem_wr_strb;
  logic              mem_wr_ack;

  modport master (
    output inv_all, req_valid, req_write, req_size, req_addr, req_wdata,
           mem_rd_valid, mem_rd_data, mem_wr_ack,
    input  req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
           mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_strb
  );

  modport slave (
    input  inv_all, req_valid, req_write, req_size, req_addr, req_wdata,
           mem_rd_valid, mem_rd_data, mem_wr_ack,
    output req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
           mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_strb
  );
endinterface

// File: rtl/cache_sa_wt.sv
// Blocking N-way set-associative L1 data cache, write-through / no write-allocate.
// Valid bits live in flops; tag and data arrays are never reset.
module cache_sa_wt #(
  parameter int ADDR_W      = 32,
  parameter int SETS        = 64,
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 16,
  parameter int REPL_MODE   = 0
) (
  input logic         clk,
  input logic         rst,
  cache_sa_wt_if.slave bus
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = 8 * BLOCK_BYTES;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, RD_WAIT, WR_WAIT, RESP} state_t;
  state_t state, next_state;

  logic              write_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              hit_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [BLK_W-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]  valid_q  [SETS];

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] woff;
  logic             accept;
  logic             inv_fire;
  logic             fill;
  logic             evict;
  logic             store_hit;

  assign tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign idx  = addr_q[OFF_W +: IDX_W];
  assign woff = addr_q[OFF_W-1:0] >> 2;

  assign accept   = (state == IDLE) && bus.req_valid && !bus.inv_all;
  assign inv_fire = (state == IDLE) && bus.inv_all;

  logic [WAYS-1:0]  hit_vec;
  logic [WAY_W-1:0] hit_way;
  logic             lookup_hit;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_mem[idx][w] == tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign lookup_hit = |hit_vec;

  logic misaligned;

  always_comb begin
    case (size_q)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_q[0];
      default: misaligned = (addr_q[1:0] != 2'b00);
    endcase
  end

  // Store data is replicated across lanes so memory can take it straight from the strobes.
  logic [3:0]  strb;
  logic [31:0] lane_data;

  always_comb begin
    strb      = 4'hF;
    lane_data = wdata_q;
    case (size_q)
      2'd0: begin
        strb      = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        strb      = 4'b0011 << addr_q[1:0];
        lane_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  logic [BLK_W-1:0] hit_line;
  logic [BLK_W-1:0] merged_line;
  logic [31:0]      hit_word;

  always_comb begin
    hit_line    = data_mem[idx][hit_way];
    hit_word    = hit_line[{woff, 5'd0} +: 32];
    merged_line = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged_line[{woff, 5'd0} + 8 * b +: 8] = lane_data[8 * b +: 8];
    end
  end

  // Prefer the lowest invalid way; only a full set falls back to the policy way.
  logic [WAYS-1:0]  set_valid;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] policy_way;
  logic             victim_found;

  always_comb begin
    set_valid    = valid_q[idx];
    victim       = policy_way;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!set_valid[w] && !victim_found) begin
        victim       = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  assign fill      = (state == RD_WAIT) && bus.mem_rd_valid;
  assign evict     = fill && !victim_found;
  assign store_hit = (state == LOOKUP) && write_q && !misaligned && lookup_hit;

  generate
    if (REPL_MODE == 0) begin : g_lfsr
      logic [7:0] lfsr;
      always_ff @(posedge clk) begin
        if (rst)        lfsr <= 8'hA5;
        else if (evict) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      assign policy_way = lfsr[WAY_W-1:0];
    end else begin : g_rr
      logic [WAY_W-1:0] rr;
      always_ff @(posedge clk) begin
        if (rst)        rr <= '0;
        else if (evict) rr <= rr + WAY_W'(1);
      end
      assign policy_way = rr;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = LOOKUP;
      LOOKUP: begin
        if (misaligned)      next_state = RESP;
        else if (write_q)    next_state = WR_WAIT;
        else if (lookup_hit) next_state = RESP;
        else                 next_state = RD_WAIT;
      end
      RD_WAIT: if (bus.mem_rd_valid) next_state = RESP;
      WR_WAIT: if (bus.mem_wr_ack)   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_rdata  = '0;
    bus.resp_hit    = 1'b0;
    bus.resp_err    = 1'b0;
    bus.mem_rd_req  = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_wr_req  = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_strb = '0;
    case (state)
      IDLE: bus.req_ready = !bus.inv_all && !rst;
      RD_WAIT: begin
        bus.mem_rd_req  = 1'b1;
        bus.mem_rd_addr = {tag, idx, OFF_W'(0)};
      end
      WR_WAIT: begin
        bus.mem_wr_req  = 1'b1;
        bus.mem_wr_addr = {addr_q[ADDR_W-1:2], 2'b00};
        bus.mem_wr_data = lane_data;
        bus.mem_wr_strb = strb;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
        bus.resp_hit   = hit_q;
        bus.resp_err   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          write_q <= bus.req_write;
          size_q  <= bus.req_size;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          hit_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        LOOKUP: begin
          err_q   <= misaligned;
          hit_q   <= lookup_hit && !misaligned;
          rdata_q <= (!misaligned && !write_q && lookup_hit) ? hit_word : 32'd0;
        end
        RD_WAIT: if (bus.mem_rd_valid) rdata_q <= bus.mem_rd_data[{woff, 5'd0} +: 32];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || inv_fire) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (fill) begin
      valid_q[idx][victim] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx][victim]  <= tag;
      data_mem[idx][victim] <= bus.mem_rd_data;
    end else if (store_hit) begin
      data_mem[idx][hit_way] <= merged_line;
    end
  end
endmodule

// File: tb/tb_cache_sa_wt.sv
// Directed self-checking bench for cache_sa_wt (round-robin replacement build).
// Memory model returns each word equal to its own address, except block 0x1000.
module tb_cache_sa_wt;
  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_sa_wt_if #(.ADDR_W(32), .BLOCK_BYTES(16)) bus ();

  cache_sa_wt #(
    .ADDR_W(32), .SETS(64), .WAYS(4), .BLOCK_BYTES(16), .REPL_MODE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [31:0] o_rdata;
  logic        o_hit;
  logic        o_err;
  logic        got_resp;
  int          lat;
  int          rd_cnt;
  int          wr_cnt;
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  function automatic logic [127:0] memBlock(input logic [31:0] a);
    if (a == 32'h1000) return 128'h0000000D_0000000C_0000000B_0000000A;
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full request, serving refills and write-throughs with zero-wait-state memory.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] wd);
    rd_cnt = 0; wr_cnt = 0; got_resp = 1'b0; lat = 0;
    o_rdata = '0; o_hit = 1'b0; o_err = 1'b0;
    @(negedge clk);
    checkOutput("req_ready_before_req", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    for (int n = 1; n <= 40 && !got_resp; n++) begin
      @(negedge clk);
      bus.req_valid    = 1'b0;
      bus.mem_rd_valid = 1'b0;
      bus.mem_wr_ack   = 1'b0;
      if (bus.resp_valid) begin
        got_resp = 1'b1;
        lat      = n;
        o_rdata  = bus.resp_rdata;
        o_hit    = bus.resp_hit;
        o_err    = bus.resp_err;
      end else begin
        if (bus.mem_rd_req) begin
          rd_cnt++;
          rd_addr          = bus.mem_rd_addr;
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = memBlock(bus.mem_rd_addr);
        end
        if (bus.mem_wr_req) begin
          wr_cnt++;
          wr_addr        = bus.mem_wr_addr;
          wr_data        = bus.mem_wr_data;
          wr_strb        = bus.mem_wr_strb;
          bus.mem_wr_ack = 1'b1;
        end
      end
    end
    checkOutput("resp_seen", 32'(got_resp), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic saw_resp;
    logic saw_rd;
    bus.inv_all      = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    bus.mem_wr_ack   = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_mem_rd_req", 32'(bus.mem_rd_req), 32'd0);
    checkOutput("rst_mem_wr_req", 32'(bus.mem_wr_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("req_ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Test 1: cold load then hit
    applyStimulus(1'b0, 2'd2, 32'h1004, 32'h0);
    checkOutput("t1_rd_addr", rd_addr, 32'h1000);
    checkOutput("t1_rd_cnt", 32'(rd_cnt), 32'd1);
    checkOutput("t1_rdata", o_rdata, 32'h0000000B);
    checkOutput("t1_hit", 32'(o_hit), 32'd0);
    checkOutput("t1_err", 32'(o_err), 32'd0);
    @(negedge clk);
    checkOutput("t1_resp_pulse", 32'(bus.resp_valid), 32'd0);
    applyStimulus(1'b0, 2'd2, 32'h1004, 32'h0);
    checkOutput("t1b_hit", 32'(o_hit), 32'd1);
    checkOutput("t1b_latency", 32'(lat), 32'd2);
    checkOutput("t1b_rd_cnt", 32'(rd_cnt), 32'd0);
    checkOutput("t1b_rdata", o_rdata, 32'h0000000B);

    // Test 2: store byte / half hit write-through and merge
    applyStimulus(1'b1, 2'd0, 32'h1005, 32'h000000AB);
    checkOutput("t2_wr_strb", 32'(wr_strb), 32'h2);
    checkOutput("t2_wr_data", wr_data, 32'hABABABAB);
    checkOutput("t2_wr_addr", wr_addr, 32'h1004);
    checkOutput("t2_hit", 32'(o_hit), 32'd1);
    checkOutput("t2_rdata", o_rdata, 32'h0);
    applyStimulus(1'b0, 2'd2, 32'h1004, 32'h0);
    checkOutput("t2_lw_rdata", o_rdata, 32'h0000AB0B);
    checkOutput("t2_lw_hit", 32'(o_hit), 32'd1);
    applyStimulus(1'b1, 2'd1, 32'h1006, 32'h0000BEEF);
    checkOutput("t2_sh_strb", 32'(wr_strb), 32'hC);
    checkOutput("t2_sh_data", wr_data, 32'hBEEFBEEF);
    applyStimulus(1'b0, 2'd2, 32'h1004, 32'h0);
    checkOutput("t2_lw2_rdata", o_rdata, 32'hBEEFAB0B);

    // Test 3: store miss does not allocate
    applyStimulus(1'b1, 2'd2, 32'h2000, 32'h12345678);
    checkOutput("t3_hit", 32'(o_hit), 32'd0);
    checkOutput("t3_wr_cnt", 32'(wr_cnt), 32'd1);
    checkOutput("t3_wr_addr", wr_addr, 32'h2000);
    checkOutput("t3_wr_strb", 32'(wr_strb), 32'hF);
    checkOutput("t3_wr_data", wr_data, 32'h12345678);
    applyStimulus(1'b0, 2'd2, 32'h2000, 32'h0);
    checkOutput("t3_lw_rd_cnt", 32'(rd_cnt), 32'd1);
    checkOutput("t3_lw_rd_addr", rd_addr, 32'h2000);
    checkOutput("t3_lw_hit", 32'(o_hit), 32'd0);
    checkOutput("t3_lw_rdata", o_rdata, 32'h2000);

    // Test 5: misaligned accesses and invalidate-all
    applyStimulus(1'b0, 2'd2, 32'h1002, 32'h0);
    checkOutput("t5_lw_err", 32'(o_err), 32'd1);
    checkOutput("t5_lw_rdata", o_rdata, 32'h0);
    checkOutput("t5_lw_hit", 32'(o_hit), 32'd0);
    checkOutput("t5_lw_mem", 32'(rd_cnt + wr_cnt), 32'd0);
    applyStimulus(1'b0, 2'd1, 32'h1001, 32'h0);
    checkOutput("t5_lh_err", 32'(o_err), 32'd1);
    checkOutput("t5_lh_mem", 32'(rd_cnt + wr_cnt), 32'd0);
    applyStimulus(1'b1, 2'd1, 32'h1003, 32'h5555);
    checkOutput("t5_sh_err", 32'(o_err), 32'd1);
    checkOutput("t5_sh_mem", 32'(rd_cnt + wr_cnt), 32'd0);
    @(negedge clk);
    bus.inv_all   = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h1004;
    #1;
    checkOutput("t5_ready_during_inv", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.inv_all   = 1'b0;
    bus.req_valid = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_rd_req) saw_resp = 1'b1;
    end
    checkOutput("t5_inv_blocks_req", 32'(saw_resp), 32'd0);
    applyStimulus(1'b0, 2'd2, 32'h1004, 32'h0);
    checkOutput("t5_after_inv_hit", 32'(o_hit), 32'd0);
    checkOutput("t5_after_inv_rd_cnt", 32'(rd_cnt), 32'd1);

    // Test 6: reset while waiting for a refill
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h3000;
    saw_rd = 1'b0;
    for (int i = 0; i < 10 && !saw_rd; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_rd_req) saw_rd = 1'b1;
    end
    checkOutput("t6_rd_req_seen", 32'(saw_rd), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_rd_req_dropped", 32'(bus.mem_rd_req), 32'd0);
    checkOutput("t6_no_resp", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_data  = memBlock(32'h3000);
    @(negedge clk);
    bus.mem_rd_valid = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid) saw_resp = 1'b1;
      @(negedge clk);
    end
    checkOutput("t6_late_valid_ignored", 32'(saw_resp), 32'd0);
    applyStimulus(1'b0, 2'd2, 32'h3000, 32'h0);
    checkOutput("t6_lw_hit", 32'(o_hit), 32'd0);
    checkOutput("t6_lw_rd_cnt", 32'(rd_cnt), 32'd1);
    checkOutput("t6_lw_rdata", o_rdata, 32'h3000);

    // Test 4: round-robin eviction within set 0
    doReset();
    applyStimulus(1'b0, 2'd2, 32'h0000, 32'h0);
    checkOutput("t4_fill0_hit", 32'(o_hit), 32'd0);
    applyStimulus(1'b0, 2'd2, 32'h0400, 32'h0);
    applyStimulus(1'b0, 2'd2, 32'h0800, 32'h0);
    applyStimulus(1'b0, 2'd2, 32'h0C00, 32'h0);
    checkOutput("t4_fill3_rd_addr", rd_addr, 32'h0C00);
    applyStimulus(1'b0, 2'd2, 32'h1000, 32'h0);
    checkOutput("t4_evict_hit", 32'(o_hit), 32'd0);
    checkOutput("t4_evict_rdata", o_rdata, 32'h0000000A);
    applyStimulus(1'b0, 2'd2, 32'h0400, 32'h0);
    checkOutput("t4_0400_hit", 32'(o_hit), 32'd1);
    checkOutput("t4_0400_rdata", o_rdata, 32'h0400);
    applyStimulus(1'b0, 2'd2, 32'h0000, 32'h0);
    checkOutput("t4_0000_miss", 32'(o_hit), 32'd0);
    checkOutput("t4_0000_rd_cnt", 32'(rd_cnt), 32'd1);
    applyStimulus(1'b0, 2'd2, 32'h0800, 32'h0);
    checkOutput("t4_0800_hit", 32'(o_hit), 32'd1);
    applyStimulus(1'b0, 2'd2, 32'h0400, 32'h0);
    checkOutput("t4_0400_evicted", 32'(o_hit), 32'd0);
    applyStimulus(1'b0, 2'd2, 32'h0C00, 32'h0);
    checkOutput("t4_0C00_hit", 32'(o_hit), 32'd1);
    applyStimulus(1'b0, 2'd2, 32'h1000, 32'h0);
    checkOutput("t4_1000_hit", 32'(o_hit), 32'd1);
    checkOutput("t4_1000_rdata", o_rdata, 32'h0000000A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
